event_trigger_mapper: RTL and testbench
=======================================

EVENT_TRIGGER_MAPPER -- requirements
Module: event_trigger_mapper

Interface
REQ-001 SHALL have parameter TRIGGER_COUNT, default 8, the number of trigger outputs (1..16).
REQ-002 SHALL have parameter HOLDOFF_WIDTH, default 16, the width of the per-trigger holdoff counter.
REQ-003 SHALL have port evrClk  input  1  event clock; the only clock.
REQ-004 SHALL have port evrResetN  input  1  reset, synchronous to evrClk, active-low.
REQ-005 SHALL have port evrRxCode  input  8  received event code.
REQ-006 SHALL have port evrRxCodeValid  input  1  evrRxCode is a data event this cycle (not K-char, no error).
REQ-007 SHALL have port cfgMapWrite  input  1  write strobe for the event map.
REQ-008 SHALL have port cfgMapAddr  input  8  event code being mapped.
REQ-009 SHALL have port cfgMapData  input  TRIGGER_COUNT  trigger bits fired by that event code.
REQ-010 SHALL have port cfgHoldoffWrite  input  1  write strobe for one holdoff register.
REQ-011 SHALL have port cfgHoldoffSel  input  4  trigger index for the holdoff write.
REQ-012 SHALL have port cfgHoldoffValue  input  HOLDOFF_WIDTH  holdoff length in evrClk cycles.
REQ-013 SHALL have port cfgEnable  input  TRIGGER_COUNT  per-trigger enable, level.
REQ-014 SHALL have port droppedClear  input  1  clears droppedCount.
REQ-015 SHALL have port triggerStrobe  output  TRIGGER_COUNT  one-cycle strobes; bit i feeds output driver i's triggerStrobe.
REQ-016 SHALL have port holdoffActive  output  TRIGGER_COUNT  bit i high while trigger i is in HOLDOFF.
REQ-017 SHALL have port droppedCount  output  16  count of cycles with at least one suppressed hit.

Function
REQ-018 SHALL hold a 256 x TRIGGER_COUNT map RAM, written on cfgMapWrite, read-first on same-address read/write.
REQ-019 SHALL, for evrRxCodeValid at input cycle n, assert triggerStrobe bits at cycle n+2 (fixed 2-cycle latency: RAM read, then decision register).
REQ-020 SHALL treat event code 0x00 as null: it never produces a hit regardless of map contents.
REQ-021 SHALL define hit[i] = valid stage-1 event AND map[i] AND cfgEnable[i] (cfgEnable sampled at stage 1).
REQ-022 SHALL run per trigger a two-state FSM: IDLE, HOLDOFF.
REQ-023 SHALL in IDLE, on hit[i], assert triggerStrobe[i] and, if holdoff[i] > 0, load counter with holdoff[i] and enter HOLDOFF; with holdoff[i] = 0 stay IDLE (back-to-back strobes allowed).
REQ-024 SHALL in HOLDOFF decrement the counter each cycle, suppress hit[i], and return to IDLE when the counter reaches 0; a hit at input cycle n suppresses hits at n+1..n+H, and a hit at n+H+1 fires.
REQ-025 SHALL apply holdoff writes to subsequent counter loads only; a running holdoff is not altered.
REQ-026 SHALL ignore cfgHoldoffWrite when cfgHoldoffSel >= TRIGGER_COUNT.
REQ-027 SHALL increment droppedCount by exactly 1 in any cycle where one or more hits are suppressed, saturating at 0xFFFF.
REQ-028 SHALL give droppedClear priority over a simultaneous increment (result 0).
REQ-029 SHALL, when cfgEnable[i] deasserts during HOLDOFF, let the counter run out normally.

Reset
REQ-030 SHALL on evrResetN low clear triggerStrobe, holdoffActive, droppedCount, all counters, all holdoff registers, and pipeline valid flags; FSMs go to IDLE.
REQ-031 SHALL drop any event in the pipeline when reset is asserted mid-operation; no strobe emerges after reset release for a pre-reset event.
REQ-032 SHALL NOT reset map RAM contents; firmware initialises the map before enabling triggers.

Configuration
REQ-033 SHALL, with macro EVENT_TRIGGER_MAPPER_DROP_COUNTER_EN defined, implement droppedCount per REQ-027/028.
REQ-034 SHALL, without EVENT_TRIGGER_MAPPER_DROP_COUNTER_EN, tie droppedCount to 0 and ignore droppedClear; suppression behaviour is unchanged.

Verification
REQ-035 SHALL cover: map[0x2A]=0x05, cfgEnable=0xFF, holdoff 0, code 0x2A at cycle 10 -> triggerStrobe=0x05 at cycle 12 only.
REQ-036 SHALL cover: map[0x00]=0xFF, code 0x00 -> triggerStrobe stays 0x00.
REQ-037 SHALL cover: holdoff[1]=4, map[0x10]=0x02, code 0x10 at cycles 20..26 -> strobes at 22 and 27 only; droppedCount=4; holdoffActive[1] high 23..26.
REQ-038 SHALL cover: cfgEnable=0xFE, map[0x11]=0x03 -> triggerStrobe=0x02.
REQ-039 SHALL cover: code 0x2A at cycle 10, evrResetN low cycle 11 only -> no strobe at 12 or later; droppedCount=0.
REQ-040 SHALL cover: droppedCount=0xFFFF plus further drops -> remains 0xFFFF; droppedClear with a drop in the same cycle -> 0; macro undefined -> droppedCount always 0.

Source files
------------

// File: rtl/event_trigger_mapper.sv
// Event-code to trigger mapper: 256-entry map RAM, per-trigger holdoff FSMs, 2-cycle strobe latency.
// Define EVENT_TRIGGER_MAPPER_DROP_COUNTER_EN to build the suppressed-hit counter (droppedCount).
module event_trigger_mapper #(
  parameter int TRIGGER_COUNT = 8,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     evrClk,
  input  logic                     evrResetN,
  input  logic [7:0]               evrRxCode,
  input  logic                     evrRxCodeValid,
  input  logic                     cfgMapWrite,
  input  logic [7:0]               cfgMapAddr,
  input  logic [TRIGGER_COUNT-1:0] cfgMapData,
  input  logic                     cfgHoldoffWrite,
  input  logic [3:0]               cfgHoldoffSel,
  input  logic [HOLDOFF_WIDTH-1:0] cfgHoldoffValue,
  input  logic [TRIGGER_COUNT-1:0] cfgEnable,
  input  logic                     droppedClear,
  output logic [TRIGGER_COUNT-1:0] triggerStrobe,
  output logic [TRIGGER_COUNT-1:0] holdoffActive,
  output logic [15:0]              droppedCount
);

  typedef enum logic {IDLE = 1'b0, HOLDOFF = 1'b1} state_t;

  logic [TRIGGER_COUNT-1:0] map_ram [256];
  logic [TRIGGER_COUNT-1:0] map_p1;
  logic                     vld_p1;

  logic [HOLDOFF_WIDTH-1:0] holdoff_q [TRIGGER_COUNT];
  logic [HOLDOFF_WIDTH-1:0] cnt_q     [TRIGGER_COUNT];
  logic [HOLDOFF_WIDTH-1:0] cnt_d     [TRIGGER_COUNT];
  state_t                   state_q   [TRIGGER_COUNT];
  state_t                   state_d   [TRIGGER_COUNT];

  logic [TRIGGER_COUNT-1:0] hit;
  logic [TRIGGER_COUNT-1:0] fire;
  logic [TRIGGER_COUNT-1:0] drop;

  // Stage 0 -> 1: map RAM read (read-first); null code 0x00 never becomes a valid event
  always_ff @(posedge evrClk) begin
    if (cfgMapWrite) map_ram[cfgMapAddr] <= cfgMapData;
    map_p1 <= map_ram[evrRxCode];
  end

  always_ff @(posedge evrClk) begin
    if (!evrResetN) vld_p1 <= 1'b0;
    else            vld_p1 <= evrRxCodeValid && (evrRxCode != 8'h00);
  end

  // Out-of-range selects match no index, so they are dropped without extra logic
  always_ff @(posedge evrClk) begin
    for (int i = 0; i < TRIGGER_COUNT; i++) begin
      if (!evrResetN) holdoff_q[i] <= '0;
      else if (cfgHoldoffWrite && (cfgHoldoffSel == 4'(i))) holdoff_q[i] <= cfgHoldoffValue;
    end
  end

  assign hit = {TRIGGER_COUNT{vld_p1}} & map_p1 & cfgEnable;

  // Stage 1 -> 2: per-trigger holdoff FSM and strobe decision register
  always_ff @(posedge evrClk) begin
    if (!evrResetN) begin
      for (int i = 0; i < TRIGGER_COUNT; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      triggerStrobe <= '0;
      holdoffActive <= '0;
    end else begin
      for (int i = 0; i < TRIGGER_COUNT; i++) begin
        state_q[i]       <= state_d[i];
        cnt_q[i]         <= cnt_d[i];
        holdoffActive[i] <= (state_q[i] == HOLDOFF);
      end
      triggerStrobe <= fire;
    end
  end

  always_comb begin
    for (int i = 0; i < TRIGGER_COUNT; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (hit[i] && (holdoff_q[i] != '0)) begin
            state_d[i] = HOLDOFF;
            cnt_d[i]   = holdoff_q[i];
          end
        end
        HOLDOFF: begin
          // Enable changes do not shorten a running holdoff
          cnt_d[i] = cnt_q[i] - HOLDOFF_WIDTH'(1);
          if (cnt_q[i] <= HOLDOFF_WIDTH'(1)) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    fire = '0;
    drop = '0;
    for (int i = 0; i < TRIGGER_COUNT; i++) begin
      fire[i] = hit[i] && (state_q[i] == IDLE);
      drop[i] = hit[i] && (state_q[i] == HOLDOFF);
    end
  end

`ifdef EVENT_TRIGGER_MAPPER_DROP_COUNTER_EN
  always_ff @(posedge evrClk) begin
    if (!evrResetN)                   droppedCount <= '0;
    else if (droppedClear)            droppedCount <= '0;
    else if ((|drop) && (droppedCount != 16'hFFFF)) droppedCount <= droppedCount + 16'd1;
  end
`else
  logic unused_drop_inputs;
  assign unused_drop_inputs = droppedClear ^ (|drop);
  assign droppedCount       = '0;
`endif

endmodule

// File: tb/tb_event_trigger_mapper.sv
// Bench for event_trigger_mapper: table vectors plus hand sequences, strobes checked through an expected-value queue.
module tb_event_trigger_mapper;
  localparam int TC = 8;
  localparam int HW = 16;
`ifdef EVENT_TRIGGER_MAPPER_DROP_COUNTER_EN
  localparam bit DROP_EN = 1'b1;
  localparam int SAT_CYC = 65540;
`else
  localparam bit DROP_EN = 1'b0;
  localparam int SAT_CYC = 20;
`endif

  logic          evrClk = 1'b0;
  logic          evrResetN;
  logic [7:0]    evrRxCode;
  logic          evrRxCodeValid;
  logic          cfgMapWrite;
  logic [7:0]    cfgMapAddr;
  logic [TC-1:0] cfgMapData;
  logic          cfgHoldoffWrite;
  logic [3:0]    cfgHoldoffSel;
  logic [HW-1:0] cfgHoldoffValue;
  logic [TC-1:0] cfgEnable;
  logic          droppedClear;
  logic [TC-1:0] triggerStrobe;
  logic [TC-1:0] holdoffActive;
  logic [15:0]   droppedCount;

  always #5 evrClk = ~evrClk;

  event_trigger_mapper #(.TRIGGER_COUNT(TC), .HOLDOFF_WIDTH(HW)) dut (
    .evrClk(evrClk), .evrResetN(evrResetN), .evrRxCode(evrRxCode), .evrRxCodeValid(evrRxCodeValid),
    .cfgMapWrite(cfgMapWrite), .cfgMapAddr(cfgMapAddr), .cfgMapData(cfgMapData),
    .cfgHoldoffWrite(cfgHoldoffWrite), .cfgHoldoffSel(cfgHoldoffSel), .cfgHoldoffValue(cfgHoldoffValue),
    .cfgEnable(cfgEnable), .droppedClear(droppedClear), .triggerStrobe(triggerStrobe),
    .holdoffActive(holdoffActive), .droppedCount(droppedCount)
  );

  typedef struct {
    logic [7:0]    code;
    logic          v;
    logic [TC-1:0] en;
    logic [TC-1:0] exp;
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  logic [TC-1:0] exp_q[$];
  vec_t          vecs[11];

  function automatic logic [15:0] exp_drop(input int n);
    return DROP_EN ? 16'(n) : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge evrClk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Input presented this cycle appears on triggerStrobe two cycles later
  task automatic step(input logic [7:0] code, input logic v, input logic [TC-1:0] exp);
    evrRxCode      = code;
    evrRxCodeValid = v;
    exp_q.push_back(exp);
    tick();
    if (exp_q.size() > 1) check("strobe", 32'(triggerStrobe), 32'(exp_q.pop_front()));
  endtask

  task automatic flush();
    step(8'h00, 1'b0, '0);
    exp_q.delete();
  endtask

  task automatic map_wr(input logic [7:0] addr, input logic [TC-1:0] data);
    cfgMapWrite = 1'b1; cfgMapAddr = addr; cfgMapData = data;
    tick();
    cfgMapWrite = 1'b0;
  endtask

  task automatic ho_wr(input logic [3:0] sel, input logic [HW-1:0] val);
    cfgHoldoffWrite = 1'b1; cfgHoldoffSel = sel; cfgHoldoffValue = val;
    tick();
    cfgHoldoffWrite = 1'b0;
  endtask

  initial begin
    evrResetN = 1'b0; evrRxCode = '0; evrRxCodeValid = 1'b0;
    cfgMapWrite = 1'b0; cfgMapAddr = '0; cfgMapData = '0;
    cfgHoldoffWrite = 1'b0; cfgHoldoffSel = '0; cfgHoldoffValue = '0;
    cfgEnable = 8'hFF; droppedClear = 1'b0;

    vecs[0]  = '{8'h2A, 1'b1, 8'hFF, 8'h05};
    vecs[1]  = '{8'h00, 1'b1, 8'hFF, 8'h00};
    vecs[2]  = '{8'h11, 1'b1, 8'hFE, 8'h02};
    vecs[3]  = '{8'h33, 1'b1, 8'hFF, 8'h81};
    vecs[4]  = '{8'h11, 1'b1, 8'hFF, 8'h03};
    vecs[5]  = '{8'h2A, 1'b1, 8'hFA, 8'h00};
    vecs[6]  = '{8'h44, 1'b1, 8'hFF, 8'h00};
    vecs[7]  = '{8'h2A, 1'b0, 8'hFF, 8'h00};
    vecs[8]  = '{8'h2A, 1'b1, 8'hFF, 8'h05};
    vecs[9]  = '{8'h2A, 1'b1, 8'hFF, 8'h05};
    vecs[10] = '{8'h33, 1'b1, 8'h7F, 8'h01};

    repeat (3) tick();
    check("rst_strobe",  32'(triggerStrobe), 32'h0);
    check("rst_holdoff", 32'(holdoffActive), 32'h0);
    check("rst_dropped", 32'(droppedCount),  32'h0);

    for (int a = 0; a < 256; a++) map_wr(8'(a), '0);
    map_wr(8'h2A, 8'h05);
    map_wr(8'h00, 8'hFF);
    map_wr(8'h10, 8'h02);
    map_wr(8'h11, 8'h03);
    map_wr(8'h33, 8'h81);
    evrResetN = 1'b1;
    repeat (2) tick();

    // Enable is sampled one cycle after its code, so it lags the code by one record
    for (int k = 0; k < 11; k++) begin
      cfgEnable = (k == 0) ? 8'hFF : vecs[k-1].en;
      step(vecs[k].code, vecs[k].v, vecs[k].exp);
    end
    cfgEnable = vecs[10].en;
    step(8'h00, 1'b0, '0);
    cfgEnable = 8'hFF;
    flush();

    // Read-first: same-cycle write is not seen by the read
    cfgMapWrite = 1'b1; cfgMapAddr = 8'h55; cfgMapData = 8'h10;
    step(8'h55, 1'b1, 8'h00);
    cfgMapWrite = 1'b0;
    step(8'h55, 1'b1, 8'h10);
    step(8'h00, 1'b0, 8'h00);
    flush();

    // Holdoff of 4 on trigger 1, code 0x10 for seven consecutive cycles
    ho_wr(4'd1, 16'd4);
    for (int k = 0; k < 12; k++) begin
      step((k < 7) ? 8'h10 : 8'h00, k < 7, (k == 0 || k == 5) ? 8'h02 : 8'h00);
      check("holdoffActive", 32'(holdoffActive),
            ((k >= 2 && k <= 5) || (k >= 7 && k <= 10)) ? 32'h2 : 32'h0);
      if (k == 5) check("dropped_4", 32'(droppedCount), 32'(exp_drop(4)));
    end
    check("dropped_5", 32'(droppedCount), 32'(exp_drop(5)));
    flush();

    // Out-of-range select must not overwrite trigger 1's holdoff
    ho_wr(4'd9, 16'd0);
    step(8'h10, 1'b1, 8'h02);
    step(8'h10, 1'b1, 8'h00);
    step(8'h00, 1'b0, 8'h00);
    flush();

    // Reset one cycle after an event kills it and clears holdoff config
    step(8'h2A, 1'b1, 8'h00);
    evrResetN = 1'b0;
    step(8'h00, 1'b0, 8'h00);
    evrResetN = 1'b1;
    step(8'h00, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h00);
    check("rst_mid_dropped", 32'(droppedCount),  32'h0);
    check("rst_mid_holdoff", 32'(holdoffActive), 32'h0);
    step(8'h10, 1'b1, 8'h02);
    step(8'h10, 1'b1, 8'h02);
    step(8'h00, 1'b0, 8'h00);
    flush();

    // Saturation and clear priority on trigger 0 with maximum holdoff
    ho_wr(4'd0, 16'hFFFF);
    map_wr(8'h20, 8'h01);
    evrRxCode = 8'h20; evrRxCodeValid = 1'b1;
    repeat (SAT_CYC) tick();
    check("dropped_sat", 32'(droppedCount), 32'(exp_drop(16'hFFFF)));
    tick();
    check("dropped_sat_hold", 32'(droppedCount), 32'(exp_drop(16'hFFFF)));
    droppedClear = 1'b1;
    tick();
    check("dropped_clear", 32'(droppedCount), 32'h0);
    droppedClear = 1'b0;
    tick();
    check("dropped_after_clear", 32'(droppedCount), 32'(exp_drop(1)));
    evrRxCodeValid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
